// File: rtl/updown_counter_if.sv
// updown_counter_if: request/load inputs and count/flag outputs of the up/down counter.
interface updown_counter_if #(
    parameter int WIDTH = 4
);
    logic             increment;
    logic             decrement;
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic [WIDTH-1:0] count;
    logic             at_max;
    logic             at_zero;
    logic             overflow;
    logic             underflow;
    modport master (
        output increment, decrement, load, load_value,
        input  count, at_max, at_zero, overflow, underflow
    );
    modport slave (
        input  increment, decrement, load, load_value,
        output count, at_max, at_zero, overflow, underflow
    );
endinterface

// File: rtl/updown_counter.sv
// updown_counter: WIDTH-bit up/down counter over 0..MAX_VALUE with clamped load and boundary pulses.
// Define UPDOWN_COUNTER_SATURATE_EN to saturate at the boundaries instead of wrapping.
module updown_counter #(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] MAX_VALUE = {WIDTH{1'b1}}
) (
    input logic            clk,
    input logic            reset,
    updown_counter_if.slave bus
);
`ifdef UPDOWN_COUNTER_SATURATE_EN
    localparam logic [WIDTH-1:0] UP_LIMIT = MAX_VALUE;
    localparam logic [WIDTH-1:0] DN_LIMIT = '0;
`else
    localparam logic [WIDTH-1:0] UP_LIMIT = '0;
    localparam logic [WIDTH-1:0] DN_LIMIT = MAX_VALUE;
`endif
    logic [WIDTH-1:0] r_count;
    logic             r_overflow;
    logic             r_underflow;
    logic [WIDTH:0]   w_sum;
    logic             w_past_max;
    logic             w_at_zero;
    logic             w_up;
    logic             w_dn;
    logic [WIDTH-1:0] w_load_clamped;
    logic [WIDTH-1:0] w_next;
    // Step computed one bit wider so the terminal comparison cannot alias.
    assign w_sum          = {1'b0, r_count} + {{WIDTH{1'b0}}, 1'b1};
    assign w_past_max     = w_sum > {1'b0, MAX_VALUE};
    assign w_at_zero      = r_count == '0;
    assign w_up           = !bus.load && bus.increment && !bus.decrement;
    assign w_dn           = !bus.load && bus.decrement && !bus.increment;
    assign w_load_clamped = (bus.load_value > MAX_VALUE) ? MAX_VALUE : bus.load_value;
    always_comb begin
        w_next = bus.load ? w_load_clamped :
                 w_up     ? (w_past_max ? UP_LIMIT : w_sum[WIDTH-1:0]) :
                 w_dn     ? (w_at_zero ? DN_LIMIT : r_count - 1'b1) :
                            r_count;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_count     <= w_next;
            r_overflow  <= w_up && w_past_max;
            r_underflow <= w_dn && w_at_zero;
        end
    end
    assign bus.count     = r_count;
    assign bus.at_max    = r_count == MAX_VALUE;
    assign bus.at_zero   = w_at_zero;
    assign bus.overflow  = r_overflow;
    assign bus.underflow = r_underflow;
endmodule

// File: doc/updown_counter.md
# updown_counter

Parametrised up/down counter with synchronous load, programmable modulus and boundary pulses. It generalises the 2-bit increment/decrement counter to WIDTH bits and an arbitrary terminal value MAX_VALUE, and adds load, boundary flags and wrap/overflow reporting. It sits in datapath control logic as a general event counter, for example for occupancy tracking, credit counting or modulo-N sequencing.

## Interface
- WIDTH, 4: counter width in bits; legal range 2..32.
- MAX_VALUE, 2**WIDTH-1: terminal count; legal range 1..2**WIDTH-1; count range is 0..MAX_VALUE.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- increment  input  1  request a step up this cycle.
- decrement  input  1  request a step down this cycle.
- load  input  1  synchronous load of load_value; has priority over increment and decrement.
- load_value  input  WIDTH  value to load; clamped to MAX_VALUE.
- count  output  WIDTH  registered counter value.
- at_max  output  1  combinational; count == MAX_VALUE.
- at_zero  output  1  combinational; count == 0.
- overflow  output  1  registered one-cycle pulse on a step up from MAX_VALUE.
- underflow  output  1  registered one-cycle pulse on a step down from 0.

## Operation
- Reset (asynchronous assert, released synchronously to clk by the integrator): count=0, overflow=0, underflow=0. This gives at_zero=1 and at_max=0.
- Priority per rising edge, evaluated on registered state:
  1. load=1: count <= min(load_value, MAX_VALUE); overflow and underflow are 0; increment and decrement are ignored.
  2. increment=1 and decrement=1: hold count; no pulses. The two requests cancel.
  3. increment=1 only:
     - count<MAX_VALUE: count+1.
     - count==MAX_VALUE: boundary case (see Configuration); overflow<=1.
  4. decrement=1 only:
     - count>0: count-1.
     - count==0: boundary case; underflow<=1.
  5. Otherwise: hold count; overflow and underflow are 0.
- overflow and underflow are high for exactly the one cycle following the qualifying edge. They are never both high.
- Arithmetic is performed at WIDTH+1 bits internally, so the comparison against MAX_VALUE never aliases. When MAX_VALUE=2**WIDTH-1, the result is identical to native modular WIDTH-bit arithmetic.
- Values of count above MAX_VALUE are unreachable.

## Timing
- Single clock domain. All state changes on the rising edge of clk.
- Latency from inputs to count, overflow and underflow: 1 cycle.
- at_max and at_zero follow count combinationally with zero added latency.
- Every input must meet setup and hold to clk. There is no handshake: a request is consumed on every edge where it is sampled high.
- Reset assertion mid-operation clears the state immediately, without waiting for clk. Any pending pulse is lost.
- The first edge after reset release behaves per the priority list.

## Configuration
- Macro UPDOWN_COUNTER_SATURATE_EN:
  - Undefined (default), wrap mode:
    - Increment at MAX_VALUE gives count=0.
    - Decrement at 0 gives count=MAX_VALUE.
  - Defined, saturating mode:
    - Increment at MAX_VALUE holds MAX_VALUE.
    - Decrement at 0 holds 0.
  - overflow and underflow pulse identically in both modes. They report an attempted step past the boundary.

## Test plan
- Reset applied asynchronously between edges with count=5 -> count=0, at_zero=1 immediately, before the next clk edge.
- WIDTH=4, MAX_VALUE=9, load=1 with load_value=7, then 3 cycles of increment=1:
  - Wrap build: count 8, 9, 0, with overflow=1 in the cycle count shows 0.
  - Saturate build: count 8, 9, 9, with overflow=1 in the cycle after the third edge.
- WIDTH=4, MAX_VALUE=9, from count=0 assert decrement=1 for 1 cycle:
  - Wrap build: count=9, underflow=1 for one cycle.
  - Saturate build: count=0, underflow=1 for one cycle.
- count=3, increment=1 and decrement=1 for 4 cycles -> count stays 3; overflow=0 and underflow=0 throughout.
- WIDTH=4, MAX_VALUE=9, load=1, increment=1, load_value=15 -> count=9 (clamped), at_max=1, overflow=0.
- WIDTH=8, default MAX_VALUE, 300 consecutive increments from 0 (wrap build) -> count=44; exactly one overflow pulse, in the cycle count shows 0.
